axis_rr_arbiter: RTL and testbench
==================================

Name: axis_rr_arbiter

Overview:
- Merges CHANNELS axis input streams onto one axis output stream using round-robin arbitration.
- Optional packet mode holds the grant on one channel until the beat carrying ilast has transferred.
- All outputs are registered, including iready. A 2-deep skid stage (output register plus buffer) sustains one beat per clock.
- Sits between multiple axis producers (counters, throttles, fifos) and a single axis consumer. Tags each beat with its source channel.

Parameters:
- WIDTH, 8: data width per channel.
- CHANNELS, 4: number of input channels, at least 2.
- PACKET, 1: 1 = grant locked until ilast transfers; 0 = re-arbitrate after every beat.
- CHANNEL_WIDTH, max(1, clog2(CHANNELS)): width of ochannel and of the internal grant index.

Ports:
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous reset, active-high.
- idata  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- ilast  in  CHANNELS  end-of-packet flag, one bit per channel.
- ivalid  in  CHANNELS  valid, one bit per channel.
- iready  out  CHANNELS  registered ready; at most one bit high.
- odata  out  WIDTH  registered output data.
- olast  out  1  registered copy of the transferred ilast.
- ochannel  out  CHANNEL_WIDTH  index of the source channel of the current odata.
- ovalid  out  1  registered output valid.
- oready  in  1  downstream ready.

Behaviour:
- Transfers:
  - Input transfer on channel i when ivalid[i] && iready[i] at a rising edge.
  - Output transfer when ovalid && oready.
- Reset (reset=1 at an edge):
  - Outputs: iready=0, ovalid=0, odata=0, olast=0, ochannel=0.
  - Internal state: grant g=0, lock=0, bvalid=0.
  - A reset mid-packet or mid-stall discards the lock and any buffered beat.
- Registered iready: iready_next[i] = (i == g_next) && !bvalid_next. Consequently iready is all-zero whenever the buffer is full.
- Output and skid stage (same rules as the codebase pipe):
  - ovalid_next = (ovalid && !oready) || bvalid || itransfer.
  - If (ovalid && !oready), the output registers hold.
  - Otherwise the output registers load from the buffer when bvalid, else from the transferring input.
  - The buffer captures an input beat when (ovalid && !oready) and an input transfer occurs; bvalid is set then.
  - bvalid clears when the output register drains.
  - ochannel and olast travel with the data in both the output registers and the buffer.
- Latency:
  - 1 clock from input transfer to ovalid.
  - Sustained 1 beat/clock with oready tied high, including at channel switches: no bubble when g changes.
- Grant selection (g_next):
  - Locked (PACKET=1, lock=1): g_next = g.
  - Transfer on g with PACKET=1 and ilast[g]=0: lock_next=1, g_next=g.
  - Transfer on g otherwise: lock_next=0; g_next = first i with ivalid[i] set, searching g+1, g+2, ... wrapping modulo CHANNELS, and ending with g itself.
  - No transfer and unlocked: g_next=g if ivalid[g]; else the first valid channel searching from g+1.
  - No valid channel at all: g_next=g.
- Arithmetic: the index search wraps modulo CHANNELS. CHANNELS need not be a power of two; indices >= CHANNELS are never produced.
- PACKET=0: lock is never set and ilast only passes through to olast.
- Protocol assumptions on the input side: ivalid dropping without a transfer is allowed, and the arbiter may move the grant away in that case. Data is never duplicated or lost.

Decomposition:
- Shared package axis_pkg holds:
  - the clog2-with-minimum-1 constant function used for CHANNEL_WIDTH;
  - the rr_next(valid, start, CHANNELS) search function, which is reused by future multi-channel axis blocks.
- One natural sub-module: axis_rr_select, purely combinational. It takes a valid vector and a start index and returns the found index plus a found flag.
- Top level: grant/lock registers, skid stage and registered iready.

Test Plan:
- Reset behaviour: reset high for 3 clocks with all ivalid=1 -> iready=0000 and ovalid=0 throughout. In the first cycle after release, iready=0001.
- Fairness: PACKET=0, ivalid=1111, oready=1, every channel sending ilast=1 -> ochannel sequence 0,1,2,3,0,... with one beat per clock and no gaps.
- Packet lock: PACKET=1, ch1 sends 3 beats (ilast on beat 3), ch2 valid throughout -> ochannel = 1,1,1,2. ch2 is never granted before ch1's ilast transfers.
- Backpressure: one channel streaming 0x10,0x11,0x12; oready=0 for 4 clocks then 1 -> odata holds 0x10 and the buffer holds 0x11. iready drops to 0 one clock after the stall is seen. Output resumes 0x11,0x12 in order with no loss or duplicate.
- Idle and wrap: CHANNELS=3, only ch2 valid, then only ch0 -> grant moves 0->2->0. ochannel never equals 3.
- Reset mid-packet: assert reset after beat 2 of a 4-beat packet on ch3 -> after release, lock=0, ovalid=0, and ch0 (if valid) is granted first.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared helpers for multi-channel AXI-stream blocks: grant-index width and
// the round-robin search used to pick the next channel.
package axis_pkg;

    localparam int RR_MAX_CHANNELS = 32;
    localparam int RR_MAX_IDX_W    = 5;

    // Width of a channel index, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // First set bit of valid at or after start, wrapping modulo channels; -1 if none.
    function automatic int rr_next(
        input logic [RR_MAX_CHANNELS-1:0] valid,
        input int                         start,
        input int                         channels
    );
        int idx;
        int result;
        result = -1;
        // Walk from the far end so the nearest hit is the one left standing.
        for (int k = RR_MAX_CHANNELS - 1; k >= 0; k--) begin
            if (k < channels) begin
                idx = start + k;
                if (idx >= channels) begin
                    idx = idx - channels;
                end
                if (valid[idx[RR_MAX_IDX_W-1:0]]) begin
                    result = idx;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/axis_rr_select.sv
// Combinational round-robin search: first valid channel from start, wrapping.
// When nothing is valid the start index is passed back with found low.
module axis_rr_select
    import axis_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int CHANNEL_WIDTH = clog2_min1(CHANNELS)
) (
    input  logic [CHANNELS-1:0]      valid,
    input  logic [CHANNEL_WIDTH-1:0] start,
    output logic [CHANNEL_WIDTH-1:0] index,
    output logic                     found
);

    logic [RR_MAX_CHANNELS-1:0] valid_ext;
    int                         result;

    always_comb begin
        valid_ext                 = '0;
        valid_ext[CHANNELS-1:0]   = valid;
        result                    = rr_next(valid_ext, int'(start), CHANNELS);
        found                     = (result >= 0);
        index                     = found ? result[CHANNEL_WIDTH-1:0] : start;
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Round-robin merge of CHANNELS AXI-stream inputs onto one tagged output,
// with optional packet locking and a two-deep registered skid stage.
module axis_rr_arbiter
    import axis_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int CHANNELS      = 4,
    parameter int PACKET        = 1,
    parameter int CHANNEL_WIDTH = clog2_min1(CHANNELS)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] idata,
    input  logic [CHANNELS-1:0]       ilast,
    input  logic [CHANNELS-1:0]       ivalid,
    output logic [CHANNELS-1:0]       iready,
    output logic [WIDTH-1:0]          odata,
    output logic                      olast,
    output logic [CHANNEL_WIDTH-1:0]  ochannel,
    output logic                      ovalid,
    input  logic                      oready
);

    localparam logic [CHANNEL_WIDTH-1:0] LAST_CH = CHANNEL_WIDTH'(CHANNELS - 1);

    logic [CHANNEL_WIDTH-1:0] g_q, g_d;
    logic                     lock_q, lock_d;
    logic [CHANNELS-1:0]      iready_q, iready_d;

    logic                     ovalid_q, ovalid_d;
    logic [WIDTH-1:0]         odata_q, odata_d;
    logic                     olast_q, olast_d;
    logic [CHANNEL_WIDTH-1:0] ochan_q, ochan_d;

    logic                     bvalid_q, bvalid_d;
    logic [WIDTH-1:0]         bdata_q, bdata_d;
    logic                     blast_q, blast_d;
    logic [CHANNEL_WIDTH-1:0] bchan_q, bchan_d;

    logic                     itransfer;
    logic                     stall;
    logic [WIDTH-1:0]         in_data;
    logic                     in_last;
    logic [CHANNEL_WIDTH-1:0] sel_start;
    logic [CHANNEL_WIDTH-1:0] sel_index;
    logic                     sel_found;

    // iready is one-hot on g_q, so only the granted channel can transfer.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        in_data = '0;
        in_last = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (CHANNEL_WIDTH'(i) == g_q) begin
                in_data = idata[i*WIDTH +: WIDTH];
                in_last = ilast[i];
            end
        end
    end

    assign itransfer = |(ivalid & iready_q);
    assign stall     = ovalid_q && !oready;

    // After a transfer the search starts past g so g itself is tried last.
    assign sel_start = itransfer ? ((g_q == LAST_CH) ? '0 : g_q + 1'b1) : g_q;

    axis_rr_select #(
        .CHANNELS      (CHANNELS),
        .CHANNEL_WIDTH (CHANNEL_WIDTH)
    ) u_select (
        .valid (ivalid),
        .start (sel_start),
        .index (sel_index),
        .found (sel_found)
    );

    always_comb begin
        g_d    = g_q;
        lock_d = lock_q;
        if (itransfer) begin
            if ((PACKET != 0) && !in_last) begin
                lock_d = 1'b1;
            end else begin
                lock_d = 1'b0;
                if (sel_found) begin
                    g_d = sel_index;
                end
            end
        end else if (!lock_q) begin
            if (sel_found) begin
                g_d = sel_index;
            end
        end
    end

    always_comb begin
        ovalid_d = stall || bvalid_q || itransfer;
        odata_d  = odata_q;
        olast_d  = olast_q;
        ochan_d  = ochan_q;
        bvalid_d = bvalid_q;
        bdata_d  = bdata_q;
        blast_d  = blast_q;
        bchan_d  = bchan_q;
        if (!stall) begin
            if (bvalid_q) begin
                odata_d = bdata_q;
                olast_d = blast_q;
                ochan_d = bchan_q;
            end else if (itransfer) begin
                odata_d = in_data;
                olast_d = in_last;
                ochan_d = g_q;
            end
            bvalid_d = 1'b0;
        end else if (itransfer) begin
            bvalid_d = 1'b1;
            bdata_d  = in_data;
            blast_d  = in_last;
            bchan_d  = g_q;
        end
    end

    always_comb begin
        iready_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            iready_d[i] = (CHANNEL_WIDTH'(i) == g_d) && !bvalid_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            g_q      <= '0;
            lock_q   <= 1'b0;
            iready_q <= '0;
            ovalid_q <= 1'b0;
            odata_q  <= '0;
            olast_q  <= 1'b0;
            ochan_q  <= '0;
            bvalid_q <= 1'b0;
        end else begin
            g_q      <= g_d;
            lock_q   <= lock_d;
            iready_q <= iready_d;
            ovalid_q <= ovalid_d;
            odata_q  <= odata_d;
            olast_q  <= olast_d;
            ochan_q  <= ochan_d;
            bvalid_q <= bvalid_d;
        end
    end

    // NOTE: the buffer payload is not reset; bvalid_q alone says whether it is live.
    always_ff @(posedge clock) begin
        bdata_q <= bdata_d;
        blast_q <= blast_d;
        bchan_q <= bchan_d;
    end

    assign iready   = iready_q;
    assign odata    = odata_q;
    assign olast    = olast_q;
    assign ochannel = ochan_q;
    assign ovalid   = ovalid_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: three configurations (4ch packet, 4ch per-beat,
// 3ch packet) driven together and compared every cycle to a queue-based model.
module tb_axis_rr_arbiter;

    logic        clock;
    logic        reset;
    logic        oready;
    logic [31:0] idata;
    logic [3:0]  ilast;
    logic [3:0]  ivalid;

    logic [3:0]  iready_pkt, iready_rr;
    logic [2:0]  iready_c3;
    logic [7:0]  odata_pkt, odata_rr, odata_c3;
    logic        olast_pkt, olast_rr, olast_c3;
    logic        ovalid_pkt, ovalid_rr, ovalid_c3;
    logic [1:0]  ochannel_pkt, ochannel_rr, ochannel_c3;

    axis_rr_arbiter #(.WIDTH(8), .CHANNELS(4), .PACKET(1)) u_pkt (
        .clock(clock), .reset(reset), .idata(idata), .ilast(ilast), .ivalid(ivalid),
        .iready(iready_pkt), .odata(odata_pkt), .olast(olast_pkt), .ochannel(ochannel_pkt),
        .ovalid(ovalid_pkt), .oready(oready)
    );

    axis_rr_arbiter #(.WIDTH(8), .CHANNELS(4), .PACKET(0)) u_rr (
        .clock(clock), .reset(reset), .idata(idata), .ilast(ilast), .ivalid(ivalid),
        .iready(iready_rr), .odata(odata_rr), .olast(olast_rr), .ochannel(ochannel_rr),
        .ovalid(ovalid_rr), .oready(oready)
    );

    axis_rr_arbiter #(.WIDTH(8), .CHANNELS(3), .PACKET(1)) u_c3 (
        .clock(clock), .reset(reset), .idata(idata[23:0]), .ilast(ilast[2:0]),
        .ivalid(ivalid[2:0]), .iready(iready_c3), .odata(odata_c3), .olast(olast_c3),
        .ochannel(ochannel_c3), .ovalid(ovalid_c3), .oready(oready)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: index 0 = u_pkt, 1 = u_rr, 2 = u_c3.
    // The skid stage is a FIFO of at most two beats; the buffer is full at two.
    int         m_g    [3];
    bit         m_lock [3];
    int         m_cnt  [3];
    logic [7:0] m_d    [3][2];
    bit         m_l    [3][2];
    int         m_c    [3][2];
    logic [3:0] m_rdy  [3];
    int         m_xfer [3];

    int n_checks = 0;
    int n_pass   = 0;
    int         obs_chan[$];
    logic [7:0] obs_data[$];
    int         b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int rr_search(input logic [3:0] v, input int start, input int n,
                                     input int fallback);
        for (int k = 0; k < n; k++) begin
            if (v[(start + k) % n]) return (start + k) % n;
        end
        return fallback;
    endfunction

    task automatic model_step(input int k);
        int n;
        int in_ch;
        bit pkt;
        n         = (k == 2) ? 3 : 4;
        pkt       = (k != 1);
        m_xfer[k] = -1;
        if (reset) begin
            m_g[k]    = 0;
            m_lock[k] = 1'b0;
            m_cnt[k]  = 0;
            m_rdy[k]  = 4'b0;
            return;
        end
        in_ch = -1;
        for (int i = 0; i < n; i++) begin
            if (m_rdy[k][i] && ivalid[i]) in_ch = i;
        end
        if (m_cnt[k] > 0 && oready) begin
            m_d[k][0] = m_d[k][1];
            m_l[k][0] = m_l[k][1];
            m_c[k][0] = m_c[k][1];
            m_cnt[k]--;
        end
        if (in_ch >= 0) begin
            m_d[k][m_cnt[k]] = idata[in_ch*8 +: 8];
            m_l[k][m_cnt[k]] = ilast[in_ch];
            m_c[k][m_cnt[k]] = in_ch;
            m_cnt[k]++;
            m_xfer[k] = in_ch;
            m_lock[k] = pkt && !ilast[in_ch];
            if (!m_lock[k]) m_g[k] = rr_search(ivalid, (m_g[k] + 1) % n, n, m_g[k]);
        end else if (!m_lock[k]) begin
            m_g[k] = rr_search(ivalid, m_g[k], n, m_g[k]);
        end
        m_rdy[k] = (m_cnt[k] < 2) ? 4'(1 << m_g[k]) : 4'b0;
    endtask

    task automatic compare(input int k, input string nm, input logic [3:0] rdy,
                           input logic v, input logic [7:0] d, input logic l,
                           input logic [1:0] c);
        check({nm, "_iready"}, 32'(rdy), 32'(m_rdy[k]));
        check({nm, "_ovalid"}, 32'(v), 32'(m_cnt[k] > 0));
        if (m_cnt[k] > 0) begin
            check({nm, "_odata"}, 32'(d), 32'(m_d[k][0]));
            check({nm, "_olast"}, 32'(l), 32'(m_l[k][0]));
            check({nm, "_ochannel"}, 32'(c), 32'(m_c[k][0]));
        end
    endtask

    task automatic cycle();
        if (ovalid_pkt === 1'b1 && oready) begin
            obs_chan.push_back(int'(ochannel_pkt));
            obs_data.push_back(odata_pkt);
        end
        @(posedge clock);
        for (int k = 0; k < 3; k++) model_step(k);
        #1;
        compare(0, "pkt", iready_pkt, ovalid_pkt, odata_pkt, olast_pkt, ochannel_pkt);
        compare(1, "rr", iready_rr, ovalid_rr, odata_rr, olast_rr, ochannel_rr);
        compare(2, "c3", {1'b0, iready_c3}, ovalid_c3, odata_c3, olast_c3, ochannel_c3);
    endtask

    initial begin
        int exp_lock_ch [4];
        exp_lock_ch = '{1, 1, 1, 2};

        // Reset held with every channel requesting.
        reset  = 1'b1;
        ivalid = 4'hf;
        ilast  = 4'hf;
        idata  = $urandom;
        oready = 1'b1;
        repeat (3) begin
            cycle();
            check("rst_iready", 32'(iready_pkt), 32'h0);
            check("rst_ovalid", 32'(ovalid_pkt), 32'h0);
        end
        check("rst_odata", 32'(odata_pkt), 32'h0);
        check("rst_ochannel", 32'(ochannel_pkt), 32'h0);
        check("rst_olast", 32'(olast_pkt), 32'h0);
        reset = 1'b0;
        cycle();
        check("rel_iready", 32'(iready_pkt), 32'h1);

        // Fairness on the per-beat instance: 0,1,2,3,... with no gaps.
        for (int j = 0; j < 12; j++) begin
            idata = $urandom;
            cycle();
            check("rr_seq_valid", 32'(ovalid_rr), 32'h1);
            check("rr_seq_chan", 32'(ochannel_rr), 32'(j % 4));
        end

        // Packet lock: ch1 sends 3 beats while ch2 stays valid.
        reset  = 1'b1;
        ivalid = 4'h0;
        cycle();
        reset = 1'b0;
        b     = 0;
        obs_chan.delete();
        obs_data.delete();
        for (int t = 0; t < 10; t++) begin
            ivalid = {2'b01, (b < 3), 1'b0};
            ilast  = {2'b01, (b == 2), 1'b0};
            idata  = {8'h00, 8'h30, 8'(8'h20 + b), 8'h00};
            cycle();
            if (m_xfer[0] == 1) b++;
        end
        check("lock_count", 32'(obs_chan.size() >= 4), 32'h1);
        for (int i = 0; i < 4; i++) check("lock_chan", 32'(obs_chan[i]), 32'(exp_lock_ch[i]));
        for (int i = 0; i < 3; i++) check("lock_data", 32'(obs_data[i]), 32'(8'h20 + i));

        // Backpressure: 0x10,0x11,0x12 on ch0 with a 4-clock stall.
        reset  = 1'b1;
        ivalid = 4'h0;
        cycle();
        reset = 1'b0;
        b     = 0;
        obs_chan.delete();
        obs_data.delete();
        for (int t = 0; t < 12; t++) begin
            ivalid = (b < 3) ? 4'h1 : 4'h0;
            ilast  = 4'hf;
            idata  = {24'h0, 8'(8'h10 + b)};
            oready = !(t >= 2 && t < 6);
            cycle();
            if (m_xfer[0] == 0) b++;
            if (t >= 2 && t < 6) begin
                check("bp_hold_data", 32'(odata_pkt), 32'h10);
                check("bp_iready_low", 32'(iready_pkt), 32'h0);
            end
        end
        oready = 1'b1;
        check("bp_count", 32'(obs_data.size()), 32'h3);
        for (int i = 0; i < 3; i++) check("bp_order", 32'(obs_data[i]), 32'(8'h10 + i));

        // Idle and wrap on the 3-channel instance: grant 0 -> 2 -> 0.
        reset  = 1'b1;
        ivalid = 4'h0;
        cycle();
        reset  = 1'b0;
        ivalid = 4'b0100;
        ilast  = 4'hf;
        idata  = $urandom;
        cycle();
        check("wrap_to2", 32'(iready_c3), 32'h4);
        cycle();
        cycle();
        ivalid = 4'b0001;
        cycle();
        check("wrap_to0", 32'(iready_c3), 32'h1);
        cycle();
        check("wrap_ovalid", 32'(ovalid_c3), 32'h1);
        check("wrap_ochan", 32'(ochannel_c3), 32'h0);

        // Reset after beat 2 of a 4-beat packet on ch3.
        reset  = 1'b1;
        ivalid = 4'h0;
        cycle();
        reset  = 1'b0;
        ivalid = 4'b1000;
        ilast  = 4'h0;
        b      = 0;
        for (int t = 0; t < 10 && b < 2; t++) begin
            idata = {8'(8'h40 + b), 24'h0};
            cycle();
            if (m_xfer[0] == 3) b++;
        end
        check("mid_beats_sent", 32'(b), 32'h2);
        reset  = 1'b1;
        ivalid = 4'b1001;
        cycle();
        check("mid_rst_ovalid", 32'(ovalid_pkt), 32'h0);
        check("mid_rst_iready", 32'(iready_pkt), 32'h0);
        reset = 1'b0;
        cycle();
        check("mid_rel_iready", 32'(iready_pkt), 32'h1);
        cycle();
        check("mid_first_chan", 32'(ochannel_pkt), 32'h0);

        // Random traffic with occasional resets.
        for (int t = 0; t < 600; t++) begin
            reset  = ($urandom_range(0, 63) == 0);
            ivalid = 4'($urandom);
            ilast  = 4'($urandom);
            idata  = $urandom;
            oready = ($urandom_range(0, 3) != 0);
            cycle();
            check("c3_chan_range", 32'(ochannel_c3 < 2'd3), 32'h1);
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
